// File: rtl/psg_mixer.sv
// psg_mixer: time-multiplexed stereo mixer for PSG channels and other sources.
// Each frame snapshots the channel samples and the register file on a sample
// tick, then accumulates one channel per clock into left/right sums with a
// per-channel 4-bit gain and pan, and finally applies master attenuation/mute.
//
// Ports:
//   clock            system clock
//   reset            synchronous active-low reset
//   ce               sample tick (one clock wide)
//   ch               packed channel samples, channel n at [n*WIDTH +: WIDTH]
//   wce, cs, wr      bus write qualifier, active-low select, active-low strobe
//   a, d             register address and write data
//   q                combinational read data for register at a
//   audio_l/audio_r  registered stereo output samples
//   valid            one-clock pulse when audio_l/audio_r update
//   busy             high while a frame is being mixed
module psg_mixer #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned OUTW     = 16,
  parameter int unsigned AW       = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ce,
  input  logic [CHANNELS*WIDTH-1:0] ch,
  input  logic                      wce,
  input  logic                      cs,
  input  logic                      wr,
  input  logic [AW-1:0]             a,
  input  logic [7:0]                d,
  output logic [7:0]                q,
  output logic [OUTW-1:0]           audio_l,
  output logic [OUTW-1:0]           audio_r,
  output logic                      valid,
  output logic                      busy
);

  localparam int unsigned PW   = WIDTH + 4;
  localparam int unsigned CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 0;
  localparam int unsigned ACCW = PW + CW;
  localparam int unsigned IW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Live register file
  logic [7:0]          r_chreg [CHANNELS];
  logic [2:0]          r_att;
  logic                r_mute;
  logic                r_ovr;

  // Per-frame snapshot
  logic [WIDTH-1:0]    r_samp  [CHANNELS];
  logic [7:0]          r_snap  [CHANNELS];
  logic [2:0]          r_att_s;
  logic                r_mute_s;

  logic [IW-1:0]       r_idx;
  logic [ACCW-1:0]     r_acc_l;
  logic [ACCW-1:0]     r_acc_r;
  logic [OUTW-1:0]     r_audio_l;
  logic [OUTW-1:0]     r_audio_r;
  logic                r_valid;
  logic                r_busy;

  logic                w_write;
  logic                w_wr_master;
  logic                w_last;
  logic [WIDTH-1:0]    w_samp;
  logic [3:0]          w_vol;
  logic                w_len;
  logic                w_ren;
  logic [PW-1:0]       w_prod;
  logic [ACCW-1:0]     w_sl;
  logic [ACCW-1:0]     w_sr;
  logic [ACCW+OUTW-1:0] w_wide_l;
  logic [ACCW+OUTW-1:0] w_wide_r;
  logic [OUTW-1:0]     w_out_l;
  logic [OUTW-1:0]     w_out_r;

  assign w_write     = wce & ~cs & ~wr;
  assign w_wr_master = w_write && (a == AW'(CHANNELS));
  assign w_last      = (r_idx == IW'(CHANNELS - 1));

  // State register
  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (ce) w_next = S_ACC;
      S_ACC:   if (w_last) w_next = S_OUT;
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Register file; a tick arriving mid-frame wins over a clearing write
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int n = 0; n < CHANNELS; n++) r_chreg[n] <= 8'hCF;
      r_att  <= 3'd0;
      r_mute <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_write) begin
        for (int n = 0; n < CHANNELS; n++)
          if (a == AW'(n)) r_chreg[n] <= d & 8'hCF;
      end
      if (w_wr_master) begin
        r_att  <= d[2:0];
        r_mute <= d[3];
      end
      if (ce && (r_state != S_IDLE)) r_ovr <= 1'b1;
      else if (w_wr_master)          r_ovr <= 1'b0;
    end
  end

  // Read mux
  always_comb begin
    q = 8'hFF;
    for (int n = 0; n < CHANNELS; n++)
      if (a == AW'(n)) q = r_chreg[n];
    if (a == AW'(CHANNELS)) q = {r_ovr, 3'b000, r_mute, r_att};
  end

  // Select the snapshot entry for the channel being accumulated
  always_comb begin
    w_samp = '0;
    w_vol  = 4'd0;
    w_len  = 1'b0;
    w_ren  = 1'b0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (r_idx == IW'(n)) begin
        w_samp = r_samp[n];
        w_vol  = r_snap[n][3:0];
        w_len  = r_snap[n][6];
        w_ren  = r_snap[n][7];
      end
    end
  end

  assign w_prod = PW'(w_samp) * PW'(w_vol);

  // Attenuate, then left-justify into OUTW (pads or truncates LSBs as needed)
  always_comb begin
    w_sl     = r_acc_l >> r_att_s;
    w_sr     = r_acc_r >> r_att_s;
    w_wide_l = {w_sl, {OUTW{1'b0}}};
    w_wide_r = {w_sr, {OUTW{1'b0}}};
    w_out_l  = r_mute_s ? '0 : w_wide_l[ACCW+OUTW-1 -: OUTW];
    w_out_r  = r_mute_s ? '0 : w_wide_r[ACCW+OUTW-1 -: OUTW];
  end

  // Frame datapath
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int n = 0; n < CHANNELS; n++) begin
        r_samp[n] <= '0;
        r_snap[n] <= 8'hCF;
      end
      r_att_s   <= 3'd0;
      r_mute_s  <= 1'b0;
      r_idx     <= '0;
      r_acc_l   <= '0;
      r_acc_r   <= '0;
      r_audio_l <= '0;
      r_audio_r <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ce) begin
            for (int n = 0; n < CHANNELS; n++) begin
              r_samp[n] <= ch[n*WIDTH +: WIDTH];
              r_snap[n] <= r_chreg[n];
            end
            r_att_s  <= r_att;
            r_mute_s <= r_mute;
            r_acc_l  <= '0;
            r_acc_r  <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b1;
          end
        end
        S_ACC: begin
          if (w_len) r_acc_l <= r_acc_l + ACCW'(w_prod);
          if (w_ren) r_acc_r <= r_acc_r + ACCW'(w_prod);
          r_idx <= r_idx + IW'(1);
        end
        S_OUT: begin
          r_audio_l <= w_out_l;
          r_audio_r <= w_out_r;
          r_valid   <= 1'b1;
          r_busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign audio_l = r_audio_l;
  assign audio_r = r_audio_r;
  assign valid   = r_valid;
  assign busy    = r_busy;

endmodule

// File: tb/tb_psg_mixer.sv
// Directed testbench for psg_mixer with default parameters (3 x 8-bit -> 16-bit).
module tb_psg_mixer;

  logic        clock;
  logic        reset;
  logic        ce;
  logic [23:0] ch;
  logic        wce;
  logic        cs;
  logic        wr;
  logic [3:0]  a;
  logic [7:0]  d;
  logic [7:0]  q;
  logic [15:0] audio_l;
  logic [15:0] audio_r;
  logic        valid;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int vcount   = 0;

  psg_mixer dut (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .ch      (ch),
    .wce     (wce),
    .cs      (cs),
    .wr      (wr),
    .a       (a),
    .d       (d),
    .q       (q),
    .audio_l (audio_l),
    .audio_r (audio_r),
    .valid   (valid),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count valid pulses away from the active edge
  always @(negedge clock) if (valid === 1'b1) vcount++;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic reg_write(input logic [3:0] addr, input logic [7:0] data);
    a = addr; d = data; wce = 1'b1; cs = 1'b0; wr = 1'b0;
    step();
    wce = 1'b0; cs = 1'b1; wr = 1'b1;
  endtask

  task automatic reg_read(input logic [3:0] addr, output logic [7:0] data);
    a = addr;
    #1;
    data = q;
  endtask

  // Pulse ce for one clock and wait (bounded) for valid; lat counts edges from ce
  task automatic frame(output int lat, output logic busy0);
    ce = 1'b1;
    step();
    ce = 1'b0;
    busy0 = busy;
    lat = 1;
    while (valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] r;
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    n_checks++; if (audio_l !== 16'h0000) $display("FAIL reset_audio_l got %h want 0000", audio_l); else n_pass++;
    n_checks++; if (audio_r !== 16'h0000) $display("FAIL reset_audio_r got %h want 0000", audio_r); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    reg_read(4'd0, r);
    n_checks++; if (r !== 8'hCF) $display("FAIL reset_q0 got %h want cf", r); else n_pass++;
    reg_read(4'd3, r);
    n_checks++; if (r !== 8'h00) $display("FAIL reset_q3 got %h want 00", r); else n_pass++;
  endtask

  task automatic test_basic();
    int lat;
    logic b0;
    logic [7:0] r;
    ch = {8'h00, 8'h40, 8'h80};
    frame(lat, b0);
    n_checks++; if (b0 !== 1'b1) $display("FAIL basic_busy_rise got %b want 1", b0); else n_pass++;
    n_checks++; if (lat !== 5) $display("FAIL basic_latency got %0d want 5", lat); else n_pass++;
    n_checks++; if (audio_l !== 16'h2D00) $display("FAIL basic_l got %h want 2d00", audio_l); else n_pass++;
    n_checks++; if (audio_r !== 16'h2D00) $display("FAIL basic_r got %h want 2d00", audio_r); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_fall got %b want 0", busy); else n_pass++;
    step();
    n_checks++; if (valid !== 1'b0) $display("FAIL basic_valid_width got %b want 0", valid); else n_pass++;
    n_checks++; if (audio_l !== 16'h2D00) $display("FAIL basic_hold got %h want 2d00", audio_l); else n_pass++;
    reg_read(4'd0, r);
    n_checks++; if (r !== 8'hCF) $display("FAIL basic_q0 got %h want cf", r); else n_pass++;
    reg_read(4'd3, r);
    n_checks++; if (r !== 8'h00) $display("FAIL basic_q3 got %h want 00", r); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic b0;
    logic [7:0] r;
    ch = {8'h00, 8'h40, 8'h80};
    frame(lat, b0);
    frame(lat, b0);  // ce issued right after valid: minimum spacing
    n_checks++; if (lat !== 5) $display("FAIL b2b_latency got %0d want 5", lat); else n_pass++;
    n_checks++; if (audio_l !== 16'h2D00) $display("FAIL b2b_l got %h want 2d00", audio_l); else n_pass++;
    reg_read(4'd3, r);
    n_checks++; if (r !== 8'h00) $display("FAIL b2b_no_overrun got %h want 00", r); else n_pass++;
  endtask

  task automatic test_pan();
    int lat;
    logic b0;
    logic [7:0] r;
    reg_write(4'd0, 8'h4F);
    reg_read(4'd0, r);
    n_checks++; if (r !== 8'h4F) $display("FAIL pan_q0 got %h want 4f", r); else n_pass++;
    reg_write(4'd2, 8'hFF);
    reg_read(4'd2, r);
    n_checks++; if (r !== 8'hCF) $display("FAIL pan_q2_reserved got %h want cf", r); else n_pass++;
    reg_write(4'd7, 8'h12);
    reg_read(4'd7, r);
    n_checks++; if (r !== 8'hFF) $display("FAIL pan_q7_unmapped got %h want ff", r); else n_pass++;
    ch = {8'h00, 8'h40, 8'h80};
    frame(lat, b0);
    n_checks++; if (audio_l !== 16'h2D00) $display("FAIL pan_l got %h want 2d00", audio_l); else n_pass++;
    n_checks++; if (audio_r !== 16'h0F00) $display("FAIL pan_r got %h want 0f00", audio_r); else n_pass++;
    reg_write(4'd0, 8'hCF);
  endtask

  task automatic test_master();
    int lat;
    logic b0;
    logic [7:0] r;
    ch = {8'hFF, 8'hFF, 8'hFF};
    frame(lat, b0);
    n_checks++; if (audio_l !== 16'hB34C) $display("FAIL full_l got %h want b34c", audio_l); else n_pass++;
    n_checks++; if (audio_r !== 16'hB34C) $display("FAIL full_r got %h want b34c", audio_r); else n_pass++;
    reg_write(4'd3, 8'h02);
    reg_read(4'd3, r);
    n_checks++; if (r !== 8'h02) $display("FAIL att_q3 got %h want 02", r); else n_pass++;
    ch = {8'h00, 8'h40, 8'h80};
    frame(lat, b0);
    n_checks++; if (audio_l !== 16'h0B40) $display("FAIL att2_l got %h want 0b40", audio_l); else n_pass++;
    n_checks++; if (audio_r !== 16'h0B40) $display("FAIL att2_r got %h want 0b40", audio_r); else n_pass++;
    reg_write(4'd3, 8'h08);
    ch = {8'hFF, 8'hFF, 8'hFF};
    frame(lat, b0);
    n_checks++; if (lat !== 5) $display("FAIL mute_latency got %0d want 5", lat); else n_pass++;
    n_checks++; if (audio_l !== 16'h0000) $display("FAIL mute_l got %h want 0000", audio_l); else n_pass++;
    n_checks++; if (audio_r !== 16'h0000) $display("FAIL mute_r got %h want 0000", audio_r); else n_pass++;
    reg_write(4'd3, 8'h00);
  endtask

  task automatic test_overrun();
    int v0;
    logic [7:0] r;
    ch = {8'h00, 8'h40, 8'h80};
    v0 = vcount;
    ce = 1'b1; step();
    ce = 1'b0; step();
    ce = 1'b1; step();
    ce = 1'b0;
    repeat (10) step();
    n_checks++; if (vcount - v0 !== 1) $display("FAIL ovr_pulses got %0d want 1", vcount - v0); else n_pass++;
    n_checks++; if (audio_l !== 16'h2D00) $display("FAIL ovr_l got %h want 2d00", audio_l); else n_pass++;
    reg_read(4'd3, r);
    n_checks++; if (r !== 8'h80) $display("FAIL ovr_set got %h want 80", r); else n_pass++;
    reg_write(4'd3, 8'h00);
    reg_read(4'd3, r);
    n_checks++; if (r !== 8'h00) $display("FAIL ovr_clear got %h want 00", r); else n_pass++;
  endtask

  task automatic test_write_during_acc();
    int lat;
    logic b0;
    ch = {8'h00, 8'h40, 8'h80};
    ce = 1'b1; step();
    ce = 1'b0;
    reg_write(4'd1, 8'hC0);  // lands while the frame is in ACC
    lat = 2;
    while (valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    n_checks++; if (lat !== 5) $display("FAIL wacc_latency got %0d want 5", lat); else n_pass++;
    n_checks++; if (audio_l !== 16'h2D00) $display("FAIL wacc_cur got %h want 2d00", audio_l); else n_pass++;
    frame(lat, b0);
    n_checks++; if (audio_l !== 16'h1E00) $display("FAIL wacc_next_l got %h want 1e00", audio_l); else n_pass++;
    n_checks++; if (audio_r !== 16'h1E00) $display("FAIL wacc_next_r got %h want 1e00", audio_r); else n_pass++;
  endtask

  task automatic test_reset_in_acc();
    int v0;
    logic [7:0] r;
    reg_write(4'd3, 8'h05);
    ch = {8'h00, 8'h40, 8'h80};
    v0 = vcount;
    ce = 1'b1; step();
    ce = 1'b0; step();
    reset = 1'b0; step();
    n_checks++; if (busy !== 1'b0) $display("FAIL racc_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (audio_l !== 16'h0000) $display("FAIL racc_l got %h want 0000", audio_l); else n_pass++;
    n_checks++; if (audio_r !== 16'h0000) $display("FAIL racc_r got %h want 0000", audio_r); else n_pass++;
    reset = 1'b1;
    repeat (8) step();
    n_checks++; if (vcount - v0 !== 0) $display("FAIL racc_pulses got %0d want 0", vcount - v0); else n_pass++;
    reg_read(4'd1, r);
    n_checks++; if (r !== 8'hCF) $display("FAIL racc_q1 got %h want cf", r); else n_pass++;
    reg_read(4'd3, r);
    n_checks++; if (r !== 8'h00) $display("FAIL racc_q3 got %h want 00", r); else n_pass++;
    reg_read(4'd5, r);
    n_checks++; if (r !== 8'hFF) $display("FAIL racc_q5 got %h want ff", r); else n_pass++;
  endtask

  initial begin
    reset = 1'b0;
    ce    = 1'b0;
    ch    = '0;
    wce   = 1'b0;
    cs    = 1'b1;
    wr    = 1'b1;
    a     = '0;
    d     = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_pan();
    test_master();
    test_overrun();
    test_write_during_acc();
    test_reset_in_acc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
